// File: rtl/shift_arbiter4.sv
// -----------------------------------------------------------------------------
// shift_arbiter4
//
// Four-requester arbiter in front of a single external rotate unit (the
// "shifter"). A request is accepted from IDLE. Rotate requests (dir 2'b10 or
// 2'b01) are sequenced through the shifter. Pass-through requests (dir 2'b00
// or 2'b11) are returned straight from the latched operand. Every result goes
// out on a shared bus with a one-hot strobe for the owner.
//
// Configuration macro:
//   SHIFT_ARB_FIXED_PRIO_EN  - when defined, fixed priority (lowest index
//                              wins) and no round-robin pointer. When
//                              undefined (default), round-robin arbitration.
//
// Parameters:
//   WR_CYC   - cycles sh_write is held high per operation.
//   RUN_CYC  - cycles from sh_write falling to sh_result being sampled.
//
// Ports:
//   aclk, aresetn          clock (rising edge), async active-low reset
//   req_valid[3:0]         per-requester request
//   req_ready[3:0]         one-hot accept pulse
//   req_dir[7:0]           2 bits per requester (10 rotl, 01 rotr, else pass)
//   req_data[63:0]         16-bit operand per requester
//   req_amt[11:0]          3-bit rotate amount per requester
//   rsp_valid[3:0]         one-hot, one-cycle result strobe
//   rsp_data[15:0]         shared result bus, held between results
//   sh_enable, sh_write    shifter enable and register-load strobe
//   sh_direction[1:0]      shifter direction
//   sh_input[15:0]         shifter operand
//   sh_coeff[2:0]          shifter amount
//   sh_result[15:0]        shifter output
//   busy                   high in any state other than IDLE
//   grant_id[1:0]          index of the current owner, valid while busy
//
// Timing note: every output is a flop. The state register names the action
// taken on the coming clock edge. An accept at edge E0 makes req_ready
// visible for cycle T. LOAD edges raise sh_write for cycles T+1..T+WR_CYC.
// RUN edges hold sh_enable with sh_write low for RUN_CYC cycles. The CAPTURE
// edge samples sh_result, so rsp_valid is seen in cycle T+1+WR_CYC+RUN_CYC.
// The FSM is back in IDLE during the strobe cycle, so the next accept can land
// on the cycle right after it.
// -----------------------------------------------------------------------------
module shift_arbiter4 #(
  parameter int WR_CYC  = 2,
  parameter int RUN_CYC = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  req_valid,
  output logic [3:0]  req_ready,
  input  logic [7:0]  req_dir,
  input  logic [63:0] req_data,
  input  logic [11:0] req_amt,
  output logic [3:0]  rsp_valid,
  output logic [15:0] rsp_data,
  output logic        sh_enable,
  output logic        sh_write,
  output logic [1:0]  sh_direction,
  output logic [15:0] sh_input,
  output logic [2:0]  sh_coeff,
  input  logic [15:0] sh_result,
  output logic        busy,
  output logic [1:0]  grant_id
);

  // The phase counter only has to reach the larger of the two phase lengths minus one.
  localparam int MAX_CYC = (WR_CYC > RUN_CYC) ? WR_CYC : RUN_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_BYPASS  = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [15:0]      lat_data_r;

  logic [3:0]  req_ready_r;
  logic [3:0]  rsp_valid_r;
  logic [15:0] rsp_data_r;
  logic        sh_enable_r;
  logic        sh_write_r;
  logic [1:0]  sh_direction_r;
  logic [15:0] sh_input_r;
  logic [2:0]  sh_coeff_r;
  logic        busy_r;
  logic [1:0]  grant_id_r;

  logic        pick_found_s;
  logic [1:0]  pick_idx_s;
  logic [1:0]  sel_dir_s;
  logic [15:0] sel_data_s;
  logic [2:0]  sel_amt_s;
  logic        sel_rotate_s;

  // One-hot encode a requester index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

`ifdef SHIFT_ARB_FIXED_PRIO_EN

  // Fixed priority: scanning downwards leaves the lowest requesting index as the winner.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[k]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = 2'(k);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

`else

  logic [1:0] ptr_r;
  logic [1:0] pick_cand_s;

  // Round-robin: scan offsets 3..0 from the pointer so the smallest offset wins.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = 2'd0;
    pick_cand_s  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      pick_cand_s = ptr_r + 2'(k);
      if (req_valid[pick_cand_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = pick_cand_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Pointer moves past the winner, and only on an accept.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_r <= 2'd0;
    end else if (state_r == ST_IDLE && pick_found_s) begin
      ptr_r <= pick_idx_s + 2'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

`endif

  // Payload mux for the winning requester.
  always_comb begin
    case (pick_idx_s)
      2'd0: begin
        sel_dir_s  = req_dir[1:0];
        sel_data_s = req_data[15:0];
        sel_amt_s  = req_amt[2:0];
      end
      2'd1: begin
        sel_dir_s  = req_dir[3:2];
        sel_data_s = req_data[31:16];
        sel_amt_s  = req_amt[5:3];
      end
      2'd2: begin
        sel_dir_s  = req_dir[5:4];
        sel_data_s = req_data[47:32];
        sel_amt_s  = req_amt[8:6];
      end
      2'd3: begin
        sel_dir_s  = req_dir[7:6];
        sel_data_s = req_data[63:48];
        sel_amt_s  = req_amt[11:9];
      end
      default: begin
        sel_dir_s  = 2'b00;
        sel_data_s = 16'h0000;
        sel_amt_s  = 3'd0;
      end
    endcase
    sel_rotate_s = (sel_dir_s == 2'b10) || (sel_dir_s == 2'b01);
  end

  // Main sequencer: state, phase counter, latched request and all registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r        <= ST_IDLE;
      cnt_r          <= '0;
      lat_data_r     <= 16'h0000;
      req_ready_r    <= 4'b0000;
      rsp_valid_r    <= 4'b0000;
      rsp_data_r     <= 16'h0000;
      sh_enable_r    <= 1'b0;
      sh_write_r     <= 1'b0;
      sh_direction_r <= 2'b00;
      sh_input_r     <= 16'h0000;
      sh_coeff_r     <= 3'd0;
      busy_r         <= 1'b0;
      grant_id_r     <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid_r <= 4'b0000;
          sh_enable_r <= 1'b0;
          sh_write_r  <= 1'b0;
          if (pick_found_s) begin
            req_ready_r <= onehot4(pick_idx_s);
            grant_id_r  <= pick_idx_s;
            lat_data_r  <= sel_data_s;
            busy_r      <= 1'b1;
            cnt_r       <= '0;
            if (sel_rotate_s) begin
              // Shifter operands are loaded here and stay put until the next rotate accept.
              sh_direction_r <= sel_dir_s;
              sh_input_r     <= sel_data_s;
              sh_coeff_r     <= sel_amt_s;
              state_r        <= ST_LOAD;
            end else begin
              state_r <= ST_BYPASS;
            end
          end else begin
            req_ready_r <= 4'b0000;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end

        ST_LOAD: begin
          req_ready_r <= 4'b0000;
          sh_enable_r <= 1'b1;
          sh_write_r  <= 1'b1;
          if (cnt_r == WR_LAST) begin
            cnt_r   <= '0;
            state_r <= ST_RUN;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end

        ST_RUN: begin
          sh_enable_r <= 1'b1;
          sh_write_r  <= 1'b0;
          if (cnt_r == RUN_LAST) begin
            cnt_r   <= '0;
            state_r <= ST_CAPTURE;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end

        ST_CAPTURE: begin
          // RUN_CYC cycles have elapsed since sh_write fell; sample the shifter now.
          rsp_data_r  <= sh_result;
          rsp_valid_r <= onehot4(grant_id_r);
          sh_enable_r <= 1'b0;
          sh_write_r  <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end

        ST_BYPASS: begin
          req_ready_r <= 4'b0000;
          rsp_data_r  <= lat_data_r;
          rsp_valid_r <= onehot4(grant_id_r);
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end

        default: begin
          req_ready_r <= 4'b0000;
          rsp_valid_r <= 4'b0000;
          sh_enable_r <= 1'b0;
          sh_write_r  <= 1'b0;
          busy_r      <= 1'b0;
          cnt_r       <= '0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;
  assign sh_enable    = sh_enable_r;
  assign sh_write     = sh_write_r;
  assign sh_direction = sh_direction_r;
  assign sh_input     = sh_input_r;
  assign sh_coeff     = sh_coeff_r;
  assign busy         = busy_r;
  assign grant_id     = grant_id_r;

endmodule

// File: tb/tb_shift_arbiter4.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter4 - self-checking bench for shift_arbiter4 (default params).
// A combinational rotate unit stands in for the external shifter. Expected
// grants and results come from a small arithmetic model of the arbitration
// rules and of rotation.
// -----------------------------------------------------------------------------
module tb_shift_arbiter4;

  localparam int WR  = 2;
  localparam int RUN = 3;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  req_valid = 4'b0000;
  logic [3:0]  req_ready;
  logic [7:0]  req_dir = 8'h00;
  logic [63:0] req_data = 64'h0;
  logic [11:0] req_amt = 12'h000;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        sh_enable;
  logic        sh_write;
  logic [1:0]  sh_direction;
  logic [15:0] sh_input;
  logic [2:0]  sh_coeff;
  logic [15:0] sh_result;
  logic        busy;
  logic [1:0]  grant_id;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // model state
  int          ptr = 0;
  logic [1:0]  m_dir [4];
  logic [15:0] m_data [4];
  int          m_amt [4];

  logic [15:0] env_rot;

  shift_arbiter4 #(.WR_CYC(WR), .RUN_CYC(RUN)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dir(req_dir), .req_data(req_data), .req_amt(req_amt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .sh_enable(sh_enable), .sh_write(sh_write),
    .sh_direction(sh_direction), .sh_input(sh_input), .sh_coeff(sh_coeff),
    .sh_result(sh_result), .busy(busy), .grant_id(grant_id)
  );

  always #5 aclk = ~aclk;

  // Stand-in shifter: rotates one bit per step; garbage when not enabled.
  always_comb begin
    env_rot = sh_input;
    for (int k = 0; k < 7; k++) begin
      if (k < int'(sh_coeff)) begin
        if (sh_direction == 2'b10) env_rot = {env_rot[14:0], env_rot[15]};
        else if (sh_direction == 2'b01) env_rot = {env_rot[0], env_rot[15:1]};
        else env_rot = env_rot;
      end else begin
        env_rot = env_rot;
      end
    end
    sh_result = sh_enable ? env_rot : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [1:0] d, input logic [15:0] x, input int a);
    logic [31:0] w;
    if (d == 2'b10) begin
      w = {x, x} << a;
      return w[31:16];
    end else if (d == 2'b01) begin
      w = {x, x} >> a;
      return w[15:0];
    end
    return x;
  endfunction

  function automatic int pick(input logic [3:0] v);
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (v[i]) return i;
`else
    for (int k = 0; k < 4; k++) if (v[(ptr + k) % 4]) return (ptr + k) % 4;
`endif
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [1:0] d, input logic [15:0] x, input logic [2:0] a);
    req_dir[2*i +: 2]  = d;
    req_data[16*i +: 16] = x;
    req_amt[3*i +: 3]  = a;
    m_dir[i]  = d;
    m_data[i] = x;
    m_amt[i]  = int'(a);
  endtask

  // Serve all pending requests; drop_all withdraws every other request at the first grant.
  task automatic serve(input bit drop_all);
    bit first = 1'b1;
    while (req_valid != 4'b0000) begin
      int n = 0;
      int g;
      int wr = 0;
      int lat = 0;
      bit en = 1'b0;
      bit quiet = 1'b1;
      bit byp;
      logic [15:0] exp_d;
      while (req_ready == 4'b0000 && n < 16) begin
        @(negedge aclk);
        n++;
      end
      check("accept_seen", 64'(req_ready != 4'b0000), 64'd1);
      if (req_ready == 4'b0000) begin
        req_valid = 4'b0000;
        break;
      end
      if (!first) check("back_to_back_accept", 64'(n), 64'd0);
      first = 1'b0;
      g = pick(req_valid);
      check("grant_onehot", 64'(req_ready), 64'(4'b0001 << g));
      check("busy_grant_id", {62'd0, busy, 1'b0} | 64'(grant_id), {62'd0, 1'b1, 1'b0} | 64'(g));
`ifndef SHIFT_ARB_FIXED_PRIO_EN
      ptr = (g + 1) % 4;
`endif
      req_valid = drop_all ? 4'b0000 : (req_valid & ~req_ready);
      byp = !(m_dir[g] == 2'b10 || m_dir[g] == 2'b01);
      exp_d = ref_result(m_dir[g], m_data[g], m_amt[g]);
      for (int k = 1; k <= 12; k++) begin
        @(negedge aclk);
        if (sh_write) wr++;
        if (sh_enable) en = 1'b1;
        if (req_ready != 4'b0000) quiet = 1'b0;
        if (rsp_valid != 4'b0000) begin
          lat = k;
          break;
        end
      end
      check("rsp_latency", 64'(lat), byp ? 64'd1 : 64'(1 + WR + RUN));
      check("rsp_valid_onehot", 64'(rsp_valid), 64'(4'b0001 << g));
      check("rsp_data", 64'(rsp_data), 64'(exp_d));
      check("sh_write_cycles", 64'(wr), byp ? 64'd0 : 64'(WR));
      check("sh_enable_seen", 64'(en), byp ? 64'd0 : 64'd1);
      check("no_ready_while_busy", 64'(quiet), 64'd1);
      @(negedge aclk);
      check("rsp_hold", {44'd0, rsp_valid, rsp_data}, {44'd0, 4'b0000, exp_d});
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge aclk);
    check("reset_outputs",
          {14'd0, req_ready, rsp_valid, rsp_data, sh_enable, sh_write, sh_direction,
           sh_input, sh_coeff, busy, grant_id}, 64'd0);
    aresetn = 1'b1;
    ptr = 0;

    // all four held, each dropped after its own grant: order from pointer 0
    set_req(0, 2'b00, 16'h1111, 3'd0);
    set_req(1, 2'b10, 16'h00F0, 3'd4);
    set_req(2, 2'b11, 16'h2222, 3'd7);
    set_req(3, 2'b01, 16'h000F, 3'd2);
    req_valid = 4'b1111;
    serve(1'b0);

    // directed examples
    set_req(0, 2'b10, 16'h8001, 3'd1);
    @(negedge aclk); req_valid = 4'b0001; serve(1'b0);
    set_req(2, 2'b01, 16'h0001, 3'd3);
    @(negedge aclk); req_valid = 4'b0100; serve(1'b0);
    set_req(1, 2'b00, 16'hABCD, 3'd5);
    @(negedge aclk); req_valid = 4'b0010; serve(1'b0);
    // zero amount still runs the shifter and returns the operand
    set_req(3, 2'b10, 16'h5A3C, 3'd0);
    @(negedge aclk); req_valid = 4'b1000; serve(1'b0);

    // a competing request withdrawn before its grant is ignored
    set_req(0, 2'b01, 16'hF00D, 3'd6);
    set_req(1, 2'b10, 16'hBEEF, 3'd2);
    @(negedge aclk); req_valid = 4'b0011; serve(1'b1);
    begin
      bit stray = 1'b0;
      repeat (8) begin
        @(negedge aclk);
        if (req_ready != 4'b0000 || rsp_valid != 4'b0000) stray = 1'b1;
      end
      check("withdrawn_ignored", 64'(stray), 64'd0);
    end

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 4; i++)
        set_req(i, 2'($urandom_range(0, 3)), 16'($urandom), 3'($urandom_range(0, 7)));
      @(negedge aclk);
      req_valid = 4'($urandom_range(1, 15));
      serve(1'b0);
    end

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    // req0 held continuously starves everyone else
    set_req(0, 2'b00, 16'h0101, 3'd0);
    @(negedge aclk); req_valid = 4'b1111;
    for (int gi = 0; gi < 3; gi++) begin
      int n = 0;
      @(negedge aclk);
      while (req_ready == 4'b0000 && n < 16) begin
        @(negedge aclk);
        n++;
      end
      check("fixed_prio_grant", 64'(req_ready), 64'd1);
    end
    req_valid = 4'b0000;
    repeat (10) @(negedge aclk);
`endif

    // reset during RUN of req3 aborts it
    set_req(3, 2'b10, 16'h1234, 3'd5);
    @(negedge aclk); req_valid = 4'b1000;
    begin
      int n = 0;
      bit seen_rv = 1'b0;
      while (req_ready == 4'b0000 && n < 16) begin
        @(negedge aclk);
        n++;
      end
      check("abort_accept", 64'(req_ready), 64'(4'b1000));
      req_valid = 4'b0000;
      repeat (4) @(negedge aclk);
      #2 aresetn = 1'b0;
      #1;
      check("abort_outputs",
            {14'd0, req_ready, rsp_valid, rsp_data, sh_enable, sh_write, sh_direction,
             sh_input, sh_coeff, busy, grant_id}, 64'd0);
      repeat (3) begin
        @(negedge aclk);
        if (rsp_valid != 4'b0000) seen_rv = 1'b1;
      end
      set_req(0, 2'b01, 16'h8000, 3'd7);
      req_valid = 4'b0001;
      aresetn = 1'b1;
      ptr = 0;
      repeat (1) begin
        if (rsp_valid != 4'b0000) seen_rv = 1'b1;
      end
      check("abort_no_rsp", 64'(seen_rv), 64'd0);
      serve(1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/shift_arbiter4.md
SHIFT_ARBITER4 -- requirements
Module: shift_arbiter4

Interface
REQ-001 The block SHALL have parameter WR_CYC, default 2, giving the number of cycles sh_write is held high per operation.
REQ-002 The block SHALL have parameter RUN_CYC, default 3, giving the number of cycles from sh_write falling to sh_result being sampled.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- req_valid  in  4  per-requester request.
- req_ready  out  4  one-hot accept pulse.
- req_dir  in  8  2 bits per requester: 2'b10 rotate-left, 2'b01 rotate-right, 2'b00/2'b11 pass-through.
- req_data  in  64  16 bits per requester, operand.
- req_amt  in  12  3 bits per requester, rotate amount 0..7.
- rsp_valid  out  4  one-hot, one-cycle result strobe.
- rsp_data  out  16  shared result bus.
- sh_enable  out  1  shifter enable.
- sh_write  out  1  shifter register-load strobe.
- sh_direction  out  2  shifter direction.
- sh_input  out  16  shifter operand.
- sh_coeff  out  3  shifter amount.
- sh_result  in  16  shifter output.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  2  index of the current owner, valid while busy.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, RUN, CAPTURE and BYPASS.
REQ-005 In IDLE with any req_valid high, the arbiter SHALL select one requester, pulse its req_ready for that one cycle, and latch its dir, data, amt and index.
REQ-006 Arbitration SHALL be round-robin: search starts at the pointer; after a grant to i, the pointer becomes (i+1) mod 4.
REQ-007 The pointer SHALL update only on an accept.
REQ-008 A granted request with dir 2'b10 or 2'b01 SHALL go to LOAD.
- In LOAD, sh_enable and sh_write SHALL be 1 for exactly WR_CYC cycles.
- sh_direction, sh_input and sh_coeff SHALL be driven from the latched values and held stable from LOAD through CAPTURE.
REQ-009 In RUN, sh_enable SHALL be 1 and sh_write 0 for exactly RUN_CYC cycles, then the FSM SHALL go to CAPTURE.
REQ-010 In CAPTURE, the block SHALL register sh_result into rsp_data, pulse rsp_valid[grant_id] for one cycle, drop sh_enable, and return to IDLE.
REQ-011 Timing for a shifter operation: accept at cycle T gives rsp_valid at T+1+WR_CYC+RUN_CYC, which is T+6 with default parameters.
REQ-012 A granted request with dir 2'b00 or 2'b11 SHALL go to BYPASS.
- It SHALL NOT assert sh_enable or sh_write.
- It SHALL set rsp_data = latched data and pulse rsp_valid at T+1, then return to IDLE.
REQ-013 No accept SHALL occur outside IDLE; req_ready SHALL be 0 in all other states.
REQ-014 The earliest next accept SHALL be the cycle after rsp_valid.
REQ-015 rsp_data SHALL hold its last value until the next CAPTURE or BYPASS.
REQ-016 Requesters hold req_valid and payload until req_ready; a req_valid that drops before grant SHALL be ignored without error.
REQ-017 At most one bit of req_ready and at most one bit of rsp_valid SHALL be high in any cycle.
REQ-018 An amount of 0 SHALL still run a full LOAD/RUN sequence, and rsp_data SHALL equal the operand.

Reset
REQ-019 On aresetn low, the block SHALL asynchronously force:
- state IDLE, pointer 0;
- req_ready 0, rsp_valid 0, rsp_data 16'h0000;
- sh_enable 0, sh_write 0, sh_direction 2'b00, sh_input 0, sh_coeff 0;
- busy 0, grant_id 0.
REQ-020 Reset mid-operation SHALL abort the operation with no rsp_valid for the aborted request.
REQ-021 The first accept after reset deassertion SHALL occur no earlier than the first rising edge with aresetn high.

Configuration
REQ-022 With SHIFT_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins) and the round-robin pointer logic SHALL be omitted.
REQ-023 Without SHIFT_ARB_FIXED_PRIO_EN defined, the round-robin behaviour of REQ-006 and REQ-007 SHALL apply.

Verification
REQ-024 Req0: dir 2'b10, data 16'h8001, amt 1 -> req_ready[0] at T, rsp_valid[0] at T+6, rsp_data 16'h0003, sh_write high for 2 cycles.
REQ-025 Req2: dir 2'b01, data 16'h0001, amt 3 -> rsp_valid[2] at T+6, rsp_data 16'h2000.
REQ-026 Req1: dir 2'b00, data 16'hABCD -> rsp_valid[1] at T+1, rsp_data 16'hABCD, sh_enable never asserted.
REQ-027 All four req_valid held high, each dropped after its own grant -> grant order 0,1,2,3 by default; with SHIFT_ARB_FIXED_PRIO_EN and req0 held continuously, only req0 is ever granted.
REQ-028 aresetn low during RUN of req3 -> all outputs at reset values immediately, no rsp_valid[3]; a new req0 after release completes normally.
